d_latch: RTL and testbench

D_LATCH -- requirements
Module: d_latch

---
 rtl/d_latch_pkg.sv | 6 +
 rtl/d_latch_cell.sv | 32 +++
 rtl/d_latch.sv | 45 ++++
 tb/tb_d_latch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/d_latch_pkg.sv
// Shared constants for the flop-based latch emulation.
// Optional capture counter: define D_LATCH_CAPTURE_CNT_EN.
package d_latch_pkg;
  localparam int CNT_W         = 16;
  localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/d_latch_cell.sv
// One-bit latch emulation: transparent on en, holds a flopped copy.
// No real latch is inferred; held is a normal edge-triggered register.
module d_latch_cell
  import d_latch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic q
);

  logic held_q;
  logic held_d;

  always_comb begin
    held_d = held_q;
    if (en) held_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) held_q <= 1'b0;
    else      held_q <= held_d;
  end

  // rst gates the bypass so q drops in the same step reset asserts
  always_comb begin
    q = 1'b0;
    if (rst) q = en ? d : held_q;
  end

endmodule

// File: rtl/d_latch.sv
// WIDTH-bit latch emulation built from independent d_latch_cell bits.
// Optional capture counter: define D_LATCH_CAPTURE_CNT_EN.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
`ifdef D_LATCH_CAPTURE_CNT_EN
  output logic [CNT_W-1:0] cap_cnt,
`endif
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_cell u_cell (
      .clk (clk),
      .rst (rst),
      .d   (d[i]),
      .en  (en),
      .q   (q[i])
    );
  end

`ifdef D_LATCH_CAPTURE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cap_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch (WIDTH=1 and WIDTH=8 instances).
// Counter checks run when D_LATCH_CAPTURE_CNT_EN is defined.
module tb_d_latch;
  import d_latch_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [0:0] d;
  logic [0:0] q;
  logic       rst8;
  logic       en8;
  logic [7:0] d8;
  logic [7:0] q8;
`ifdef D_LATCH_CAPTURE_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt8;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  d_latch #(.WIDTH(1)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .en      (en),
`ifdef D_LATCH_CAPTURE_CNT_EN
    .cap_cnt (cnt),
`endif
    .q       (q)
  );

  d_latch #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst8),
    .d       (d8),
    .en      (en8),
`ifdef D_LATCH_CAPTURE_CNT_EN
    .cap_cnt (cnt8),
`endif
    .q       (q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic r;
    logic e;
    logic dv;
    logic x;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [15:0] act);
    logic [15:0] ex;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h want scoreboard entry", nm, act);
    end else begin
      ex = sb.pop_front();
      if (act !== ex) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm, act, ex);
      end
    end
  endtask

  task automatic drv(input logic r, input logic e,
                     input logic dv, input logic x);
    rst = r;
    en  = e;
    d   = dv;
    sb.push_back({15'b0, x});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; d = 1'b0;
    rst8 = 1'b0; en8 = 1'b0; d8 = 8'h00;

    // r, en, d, expected q; each row lands at a negedge
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drv(tbl[i].r, tbl[i].e, tbl[i].dv, tbl[i].x);
      #1 chk($sformatf("vec%0d", i), {15'b0, q});
    end

    // zero-delay transparency between edges
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("transp0", {15'b0, q});
    drv(1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("transp1", {15'b0, q});
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("transp2", {15'b0, q});

    // reset mid-transparency, then release with en=0
    drv(1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("pre_rst", {15'b0, q});
    drv(1'b0, 1'b1, 1'b1, 1'b0);
    #1 chk("mid_rst", {15'b0, q});
    @(posedge clk);
    #1;
    sb.push_back(16'h0);
    chk("rst_edge", {15'b0, q});
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b1, 1'b0);
    #1 chk("no_restore", {15'b0, q});
    @(posedge clk);
    #1;
    sb.push_back(16'h0);
    chk("hold_after", {15'b0, q});

    // width 8
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b1; d8 = 8'hA5;
    sb.push_back(16'h00A5);
    #1 chk("w8_transp", {8'b0, q8});
    @(negedge clk);
    en8 = 1'b0; d8 = 8'h3C;
    sb.push_back(16'h00A5);
    #1 chk("w8_hold", {8'b0, q8});
    rst8 = 1'b0;
    sb.push_back(16'h0000);
    #1 chk("w8_rst", {8'b0, q8});

`ifdef D_LATCH_CAPTURE_CNT_EN
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    sb.push_back(16'h0);
    #1 chk("cnt_rst", cnt);
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(16'd5);
    chk("cnt_5", cnt);
    @(negedge clk);
    en = 1'b1;
    repeat (65530) @(posedge clk);
    #1;
    sb.push_back(16'hFFFF);
    chk("cnt_max", cnt);
    @(posedge clk);
    #1;
    sb.push_back(16'h0000);
    chk("cnt_wrap", cnt);
    en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
